// File: rtl/madd_rr_sched_if.sv
// Bus bundle for madd_rr_sched: requester handshake, shared datapath hookup,
// response channel and status/checker outputs.
interface madd_rr_sched_if;
    logic [3:0]  req_valid;
    logic [23:0] req_opnd;
    logic [3:0]  req_ready;
    logic [5:0]  dp_in;
    logic [3:0]  dp_out;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_data;
    logic        rsp_ready;
    logic        busy;
    logic [7:0]  err_cnt;
    logic        err_flag;

    modport slave (
        input  req_valid, req_opnd, dp_out, rsp_ready,
        output req_ready, dp_in, rsp_valid, rsp_id, rsp_data, busy, err_cnt, err_flag
    );

    modport master (
        output req_valid, req_opnd, dp_out, rsp_ready,
        input  req_ready, dp_in, rsp_valid, rsp_id, rsp_data, busy, err_cnt, err_flag
    );
endinterface

// File: rtl/madd_rr_sched.sv
// Round-robin scheduler sharing one combinational a*b+c datapath among 4 requesters.
// Define MADD_RR_SCHED_ERRCHK_EN to build in the exact-result error checker.
module madd_rr_sched #(
    parameter int ET_THR = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    madd_rr_sched_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] id_q, id_d;
    logic [5:0] op_q, op_d;
    logic [3:0] res_q, res_d;
    logic [1:0] sync_q, sync_d;

    logic [1:0] idx, gnt;
    logic       gnt_vld;
    logic [5:0] gnt_word;

    // Search ptr, ptr+1, ... ; iterating downward lets the nearest hit win.
    always_comb begin
        idx      = '0;
        gnt      = '0;
        gnt_vld  = 1'b0;
        gnt_word = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (bus.req_valid[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++)
            if (gnt == 2'(i)) gnt_word = bus.req_opnd[6*i +: 6];
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        op_d          = op_q;
        res_d         = res_q;
        sync_d        = {sync_q[0], 1'b1};
        bus.req_ready = '0;
        case (state_q)
            IDLE: begin
                // Hold off grants until the reset release has been synchronized.
                if (sync_q[1] && gnt_vld) begin
                    bus.req_ready[gnt] = 1'b1;
                    op_d               = gnt_word;
                    id_d               = gnt;
                    state_d            = EXEC;
                end
            end
            EXEC: begin
                res_d   = bus.dp_out;
                state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    ptr_d   = id_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            res_q   <= res_d;
            sync_q  <= sync_d;
        end
    end

    assign bus.dp_in     = op_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = (state_q == RESP) ? id_q  : 2'd0;
    assign bus.rsp_data  = (state_q == RESP) ? res_q : 4'd0;

`ifdef MADD_RR_SCHED_ERRCHK_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_flag_q, err_flag_d;
    logic [3:0] exact, diff;
    logic       viol;

    always_comb begin
        exact      = {2'b0, op_q[1:0]} * {2'b0, op_q[3:2]} + {2'b0, op_q[5:4]};
        diff       = (bus.dp_out >= exact) ? bus.dp_out - exact : exact - bus.dp_out;
        viol       = (state_q == EXEC) && (int'(diff) > ET_THR);
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        if (viol) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign bus.err_cnt  = err_cnt_q;
    assign bus.err_flag = err_flag_q;
`else
    assign bus.err_cnt  = 8'd0;
    assign bus.err_flag = 1'b0;
`endif
endmodule
